// File: rtl/rng_pkg.sv
// Shared constants and FSM state type for the range-limited RNG.
package rng_pkg;
  localparam logic [31:0] TAPS_DEF = 32'h80200003;  // x^32+x^22+x^2+x+1
  localparam logic [31:0] SEED_DEF = 32'hACE12468;

  typedef enum logic {SEARCH = 1'b0, HOLD = 1'b1} fsm_t;
endpackage

// File: rtl/rng_range_if.sv
// Reseed/limit controls and valid/ready result stream of the RNG.
interface rng_range_if #(
  parameter int OUT_W  = 12,
  parameter int LFSR_W = 32
);
  logic              seed_load;
  logic [LFSR_W-1:0] seed_in;
  logic [OUT_W-1:0]  limit;
  logic              rand_ready;
  logic              rand_valid;
  logic [OUT_W-1:0]  rand_value;

  modport master (
    input  seed_load, seed_in, limit, rand_ready,
    output rand_valid, rand_value
  );
  modport slave (
    output seed_load, seed_in, limit, rand_ready,
    input  rand_valid, rand_value
  );
endinterface

// File: rtl/rng_range_lfsr_galois.sv
// Right-shifting Galois LFSR: state register plus combinational next-state.
module lfsr_galois
  import rng_pkg::*;
#(
  parameter int                LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(TAPS_DEF),
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] next
);
  assign next = (state >> 1) ^ (state[0] ? TAPS : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state <= SEED_DEFAULT;
    else if (load) state <= load_val;
    else           state <= next;
  end
endmodule

// File: rtl/rng_range.sv
// Free-running LFSR feeding a rejection sampler; delivers uniform values in [0, limit).
module rng_range
  import rng_pkg::*;
#(
  parameter int                OUT_W        = 12,
  parameter int                LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(TAPS_DEF),
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(SEED_DEF)
) (
  input logic          clk,
  input logic          rst,
  rng_range_if.master  bus
);
  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt, load_val;
  logic [OUT_W-1:0]  cand, rand_q, rand_d;
  logic              accept, valid_q, valid_d;
  fsm_t              state_q, state_d;

  // An all-zero seed would lock the LFSR, so fall back to the default seed.
  assign load_val = (bus.seed_in == '0) ? SEED_DEFAULT : bus.seed_in;

  lfsr_galois #(
    .LFSR_W(LFSR_W), .TAPS(TAPS), .SEED_DEFAULT(SEED_DEFAULT)
  ) u_lfsr (
    .clk(clk), .rst(rst), .load(bus.seed_load), .load_val(load_val),
    .state(lfsr_q), .next(lfsr_nxt)
  );

  // Only the low candidate bits are consumed; the rest just keep the LFSR period.
  logic unused_bits;
  assign unused_bits = ^{lfsr_q, lfsr_nxt};

  assign cand   = lfsr_nxt[OUT_W-1:0];
  assign accept = (bus.limit == '0) || (cand < bus.limit);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    rand_d  = rand_q;
    if (bus.seed_load) begin
      // Reseed drops any held value, even one being handshaken this cycle.
      state_d = SEARCH;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        SEARCH: if (accept) begin
          rand_d  = cand;
          valid_d = 1'b1;
          state_d = HOLD;
        end
        HOLD: if (bus.rand_ready) begin
          valid_d = 1'b0;
          state_d = SEARCH;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
      valid_q <= 1'b0;
      rand_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rand_q  <= rand_d;
    end
  end

  assign bus.rand_valid = valid_q;
  assign bus.rand_value = rand_q;
endmodule

// File: tb/tb_rng_range.sv
// Randomized bench for rng_range against a cycle-level model of the sampler rules.
module tb_rng_range;
  localparam int          OUT_W = 12;
  localparam int          LW    = 32;
  localparam logic [31:0] TAPS  = 32'h80200003;
  localparam logic [31:0] SEED  = 32'hACE12468;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rng_range_if #(.OUT_W(OUT_W), .LFSR_W(LW)) bus ();
  rng_range dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_rise = -1;
  int m_hs = 0, d_hs = 0;
  logic prev_valid = 1'b0;

  logic [LW-1:0]    m_lfsr;
  logic             m_valid;
  logic [OUT_W-1:0] m_rand;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED; m_valid = 1'b0; m_rand = '0; prev_valid = 1'b0; last_rise = -1;
  endtask

  // Reference: apply the sampler rules for one clock edge.
  task automatic model_step();
    logic [LW-1:0] n;
    if (bus.seed_load) begin
      m_lfsr  = (bus.seed_in == 0) ? SEED : bus.seed_in;
      m_valid = 1'b0;
    end else begin
      n = (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 32'h0);
      m_lfsr = n;
      if (!m_valid) begin
        if (bus.limit == 0 || n[OUT_W-1:0] < bus.limit) begin
          m_rand  = n[OUT_W-1:0];
          m_valid = 1'b1;
        end
      end else if (bus.rand_ready) begin
        m_valid = 1'b0;
        m_hs++;
      end
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic cycle(input bit chk_lfsr = 1'b0);
    if (bus.rand_valid && bus.rand_ready && !bus.seed_load) d_hs++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk("valid", bus.rand_valid, m_valid);
    if (m_valid) chk("rand", bus.rand_value, m_rand);
    if (bus.rand_valid && !prev_valid) begin
      if (last_rise >= 0) chk("gap_ge2", (cyc - last_rise) >= 2, 1);
      last_rise = cyc;
    end
    prev_valid = bus.rand_valid;
    if (chk_lfsr) begin
      chk("lfsr_nz", dut.lfsr_q == 0, 0);
      chk("lfsr", dut.lfsr_q, m_lfsr);
    end
  endtask

  initial begin
    bus.seed_load = 1'b0; bus.seed_in = '0; bus.limit = '0; bus.rand_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.rand_valid, 0);
    chk("rst_rand", bus.rand_value, 0);
    rst = 1'b0;

    // 1: first value after reset, held while not ready
    cycle(1'b1);
    chk("s1_first", bus.rand_value, 12'h234);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("s1_hold", bus.rand_value, 12'h234);
    end

    // 2: reseed with 1, limit 0x100
    bus.seed_load = 1'b1; bus.seed_in = 32'h1; bus.limit = 12'h100; bus.rand_ready = 1'b1;
    cycle(1'b1);
    bus.seed_load = 1'b0;
    cycle(1'b1);
    chk("s2_first_v", bus.rand_valid, 1);
    chk("s2_first", bus.rand_value, 12'h003);
    for (int i = 0; i < 300; i++) begin
      bus.rand_ready = 1'($urandom_range(0, 1));
      cycle();
      if (bus.rand_valid) chk("s2_lt_limit", bus.rand_value < 12'h100, 1);
    end

    // 3: zero seed falls back to default; long run with random limit/ready
    bus.seed_load = 1'b1; bus.seed_in = '0; bus.limit = '0; bus.rand_ready = 1'b0;
    cycle();
    bus.seed_load = 1'b0;
    cycle(1'b1);
    chk("s3_first", bus.rand_value, 12'h234);
    for (int i = 0; i < 10000; i++) begin
      bus.rand_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) bus.limit = 12'($urandom);
      cycle(1'b1);
    end

    // 4: limit 1 only ever yields 0; then limit 0 with ready gives one per 2 cycles
    bus.limit = 12'h001; bus.rand_ready = 1'b1;
    m_hs = 0; d_hs = 0;
    for (int i = 0; i < 2000; i++) begin
      cycle();
      if (bus.rand_valid) chk("s4_zero", bus.rand_value, 0);
    end
    chk("s4_count", d_hs, m_hs);
    bus.limit = '0;
    for (int i = 0; i < 20; i++) cycle();
    chk("s4_full_count", d_hs, m_hs);

    // 5: reseed during HOLD with ready high drops the held value
    bus.rand_ready = 1'b0;
    cycle();
    chk("s5_hold", bus.rand_valid, 1);
    m_hs = 0; d_hs = 0;
    bus.seed_load = 1'b1; bus.seed_in = $urandom | 32'h1; bus.rand_ready = 1'b1;
    cycle(1'b1);
    chk("s5_dropped", bus.rand_valid, 0);
    bus.seed_load = 1'b0;
    for (int i = 0; i < 50; i++) begin
      bus.rand_ready = 1'($urandom_range(0, 1));
      cycle(1'b1);
    end
    chk("s5_count", d_hs, m_hs);

    // 6: asynchronous reset mid-cycle while holding a value
    bus.limit = '0; bus.rand_ready = 1'b0;
    cycle();
    chk("s6_hold", bus.rand_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("s6_async_valid", bus.rand_valid, 0);
    chk("s6_async_rand", bus.rand_value, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1);
    chk("s6_restart", bus.rand_value, 12'h234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rng_range.md
Name: rng_range

Overview:
- Parametrised successor to the free-running 12-bit RNG used by the key-generation/decryption datapath.
- A Galois LFSR with configurable width feeds a rejection sampler, which delivers uniformly distributed values in [0, limit) over a valid/ready handshake.
- Supports runtime reseeding with a guard against the all-zero seed.
- Feeds prime/exponent candidate generation upstream of the modular-arithmetic units.

Parameters:
OUT_W, 12, width of delivered random value (OUT_W <= LFSR_W)
LFSR_W, 32, LFSR state width
TAPS, 32'h80200003, Galois feedback mask (x^32+x^22+x^2+x+1), LFSR_W bits
SEED_DEFAULT, 32'hACE12468, reset/fallback seed, non-zero, LFSR_W bits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
seed_load  in  1  synchronous reseed strobe
seed_in  in  LFSR_W  seed value, sampled when seed_load=1
limit  in  OUT_W  exclusive upper bound; 0 = full range 2^OUT_W
rand_ready  in  1  consumer accepts rand this cycle
rand_valid  out  1  rand holds an accepted value
rand  out  OUT_W  random value, unsigned

Behaviour:
- One clock and one reset. Reset is asynchronous and active-high.
- Reset values: lfsr=SEED_DEFAULT, rand=0, rand_valid=0, FSM=SEARCH. Reset takes effect immediately on assertion, including mid-handshake.
- LFSR step (Galois, right shift): nxt = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
- The LFSR steps on every clock edge when not in reset and seed_load=0, in both FSM states (free-running).
- Candidate: cand = nxt[OUT_W-1:0].
- Accept rule: accept = (limit==0) || (cand < limit), compared unsigned at OUT_W bits.
- FSM SEARCH:
  - rand_valid=0.
  - On each edge: if accept, then rand<=cand, rand_valid<=1, go to HOLD. Otherwise stay in SEARCH (rejected candidate discarded).
- FSM HOLD:
  - rand and rand_valid=1 are held stable.
  - If rand_ready=1, the handshake completes on that edge: rand_valid<=0, go to SEARCH. rand keeps its old value until the next accept.
  - If rand_ready=0, stay in HOLD indefinitely.
- Latency: the earliest rand_valid is 1 cycle after reset deassertion or after seed_load. After a handshake, the next valid appears at least 1 cycle later (no back-to-back delivery; max throughput is one value per 2 cycles).
- seed_load=1 (highest priority after rst):
  - lfsr <= (seed_in==0) ? SEED_DEFAULT : seed_in.
  - rand_valid<=0, FSM<=SEARCH.
  - Any held, unconsumed value is discarded, even if rand_ready=1 in the same cycle (that handshake does not count).
  - No candidate is evaluated that cycle.
- limit changes:
  - Sampled only in SEARCH.
  - A value already held in HOLD is not rechecked against a new limit.
- Boundary cases:
  - limit=1: only 0 is ever delivered.
  - limit=0: every candidate is accepted (valid 1 cycle after each SEARCH entry).
  - An all-zero LFSR state is unreachable by construction.
- rand_ready while in SEARCH is ignored.

Decomposition:
- Package rng_pkg holds the default TAPS and SEED_DEFAULT constants for LFSR_W=32 and the FSM state typedef {SEARCH, HOLD}.
- One natural sub-module: lfsr_galois (parameters LFSR_W, TAPS, SEED_DEFAULT; ports clk, rst, load, load_val, state, next). It is combinational step logic plus a state register.
- rng_range contains the zero-seed guard, comparator, FSM and output registers.

Test Plan:
1. Reset deassert, limit=0, rand_ready=0 -> at the 1st edge rand_valid=1, rand=12'h234 (0xACE12468>>1). rand stays 12'h234 for 10 cycles while ready=0.
2. seed_load=1 with seed_in=32'h1, limit=12'h100, ready=1 -> next state 32'h80200003, cand 12'h003 accepted: rand_valid=1, rand=12'h003 one cycle after load. Subsequent outputs match the bit-accurate model and are all < 12'h100.
3. seed_load=1 with seed_in=0 -> behaves identically to scenario 1 (first rand=12'h234). Zero never appears as LFSR state over 10k cycles.
4. limit=12'h001, ready=1, run 2000 cycles -> every delivered rand==0. Valid-to-valid gap >=2 cycles. Delivery count matches the model.
5. While HOLD with rand_valid=1: assert seed_load together with rand_ready=1 -> rand_valid=0 next cycle, no handshake counted, and the next value follows the new seed per the model.
6. Assert rst asynchronously mid-cycle during HOLD -> rand_valid and rand go to 0 before the next clock edge. After release, the sequence restarts at 12'h234 (limit=0).
